// File: rtl/param_ram_pkg.sv
// Shared constants and controller state encoding for the parameter RAM, its controller and the neuron engine.
package param_ram_pkg;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RD   = 3'd2,
        CAP  = 3'd3,
        HOLD = 3'd4
    } state_t;

endpackage

// File: rtl/param_ram_ctrl.sv
// Parameter RAM initiator: host weight load (1 word / 2 cycles), then a DEPTH-entry valid/ready stream (3 cycles/word).
// PARAM_RAM_CTRL_LOOP_EN: stream passes repeat until a start pulse arrives while busy.
module param_ram_ctrl #(
    parameter int DEPTH  = param_ram_pkg::DEPTH,
    parameter int ADDR_W = param_ram_pkg::ADDR_W,
    parameter int DATA_W = param_ram_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hostWrValid,
    input  logic [DATA_W-1:0] hostWrData,
    output logic              hostWrReady,
    input  logic              start,
    output logic              ramReadEn,
    output logic [ADDR_W-1:0] ramReadAdd,
    output logic              ramWriteEn,
    output logic [ADDR_W-1:0] ramWriteAdd,
    output logic [DATA_W-1:0] ramDataIn,
    input  logic [DATA_W-1:0] ramDataOut,
    output logic              outValid,
    output logic [DATA_W-1:0] outData,
    output logic [ADDR_W-1:0] outIndex,
    output logic              outLast,
    input  logic              outReady,
    output logic              busy,
    output logic [ADDR_W:0]   loadCount
);
    import param_ram_pkg::*;

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_add_q;
    logic [ADDR_W:0]   load_cnt;
    logic              out_vld_q;
    logic [DATA_W-1:0] out_dat_q;
    logic [ADDR_W-1:0] out_idx_q;
    logic              out_last_q;
    logic              wr_full;
    logic              out_hs;
    logic              loop_again;

    assign wr_full = (load_cnt == FULL_CNT);
    assign out_hs  = out_vld_q && outReady;

`ifdef PARAM_RAM_CTRL_LOOP_EN
    logic stop_req;

    // A start seen while busy ends the loop at the next outLast handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            stop_req <= 1'b0;
        end else if (state == IDLE) begin
            stop_req <= 1'b0;
        end else if (start) begin
            stop_req <= 1'b1;
        end
    end

    assign loop_again = !stop_req;
`else
    assign loop_again = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        ramReadEn   = 1'b0;
        ramWriteEn  = 1'b0;
        hostWrReady = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RD;
                end else if (hostWrValid && !wr_full) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                ramWriteEn  = 1'b1;
                hostWrReady = 1'b1;
                state_nxt   = IDLE;
            end
            RD: begin
                ramReadEn = 1'b1;
                state_nxt = CAP;
            end
            CAP: begin
                ramReadEn = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: begin
                if (out_hs) begin
                    state_nxt = (out_last_q && !loop_again) ? IDLE : RD;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            wr_add_q   <= '0;
            load_cnt   <= '0;
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            out_idx_q  <= '0;
            out_last_q <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                rd_ptr <= '0;
            end
            // Latch the write address on entry so it still holds once the pointer advances.
            if (state == IDLE && !start && hostWrValid && !wr_full) begin
                wr_add_q <= wr_ptr;
            end
            if (state == LOAD) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (!wr_full) begin
                    load_cnt <= load_cnt + 1'b1;
                end
            end
            if (state == CAP) begin
                out_dat_q  <= ramDataOut;
                out_idx_q  <= rd_ptr;
                out_last_q <= (rd_ptr == LAST_IDX);
                out_vld_q  <= 1'b1;
            end
            if (state == HOLD && out_hs) begin
                out_vld_q <= 1'b0;
                // Pointer stays on the last entry after a single pass so the read address holds.
                if (!out_last_q || loop_again) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end
    end

    assign ramReadAdd  = rd_ptr;
    assign ramWriteAdd = wr_add_q;
    assign ramDataIn   = (state == LOAD) ? hostWrData : '0;
    assign outValid    = out_vld_q;
    assign outData     = out_dat_q;
    assign outIndex    = out_idx_q;
    assign outLast     = out_last_q;
    assign busy        = (state != IDLE);
    assign loadCount   = load_cnt;

endmodule

// File: tb/tb_param_ram_ctrl.sv
// Directed bench for param_ram_ctrl with a behavioural RAM; expected values are hand-derived constants.
module tb_param_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        hostWrValid;
    logic [15:0] hostWrData;
    logic        hostWrReady;
    logic        start;
    logic        ramReadEn;
    logic [2:0]  ramReadAdd;
    logic        ramWriteEn;
    logic [2:0]  ramWriteAdd;
    logic [15:0] ramDataIn;
    logic [15:0] ramDataOut;
    logic        outValid;
    logic [15:0] outData;
    logic [2:0]  outIndex;
    logic        outLast;
    logic        outReady;
    logic        busy;
    logic [3:0]  loadCount;

    logic [15:0] mem [8];
    logic [15:0] exp_mem [8];
    int          n_chk = 0;
    int          n_err = 0;
    int          excl_viol = 0;

    always #5 clk = ~clk;

    param_ram_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .hostWrValid (hostWrValid),
        .hostWrData  (hostWrData),
        .hostWrReady (hostWrReady),
        .start       (start),
        .ramReadEn   (ramReadEn),
        .ramReadAdd  (ramReadAdd),
        .ramWriteEn  (ramWriteEn),
        .ramWriteAdd (ramWriteAdd),
        .ramDataIn   (ramDataIn),
        .ramDataOut  (ramDataOut),
        .outValid    (outValid),
        .outData     (outData),
        .outIndex    (outIndex),
        .outLast     (outLast),
        .outReady    (outReady),
        .busy        (busy),
        .loadCount   (loadCount)
    );

    always @(posedge clk) begin
        if (ramWriteEn) mem[ramWriteAdd] <= ramDataIn;
    end
    assign ramDataOut = mem[ramReadAdd];

    always @(negedge clk) begin
        if (ramReadEn && ramWriteEn) excl_viol++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] all_outs();
        return {hostWrReady, ramReadEn, ramReadAdd, ramWriteEn, ramWriteAdd, ramDataIn,
                outValid, outData, outIndex, outLast, busy, loadCount};
    endfunction

    // Wait for a word, optionally stall it, check it against the expected table, then handshake.
    task automatic expect_word(input int k, input int stall);
        int n = 0;
        while (!outValid && n < 20) begin
            tick();
            n++;
        end
        chk($sformatf("vld_timeout_%0d", k), outValid, 1'b1);
        if (stall > 0) begin
            outReady = 1'b0;
            for (int s = 0; s < stall; s++) begin
                tick();
                chk($sformatf("stall_hold_%0d_%0d", k, s), {outValid, ramReadEn, outData},
                    {1'b1, 1'b0, exp_mem[k]});
            end
            outReady = 1'b1;
        end
        chk($sformatf("word_%0d", k), {outData, 1'b0, outIndex, 3'b0, outLast},
            {exp_mem[k], 1'b0, 3'(k), 3'b0, (k == 7)});
        tick();
    endtask

    initial begin
        rst = 1'b1; hostWrValid = 1'b0; hostWrData = '0; start = 1'b0; outReady = 1'b0;
        tick(); tick();
        chk("reset_outs", all_outs(), 64'd0);
        rst = 1'b0;

        // Load 0x1000..0x1007, one word every two cycles.
        hostWrValid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            hostWrData = 16'h1000 + 16'(i);
            exp_mem[i] = 16'h1000 + 16'(i);
            tick();
            chk($sformatf("load_wr_%0d", i), {hostWrReady, ramWriteEn, 1'b0, ramWriteAdd, ramDataIn},
                {1'b1, 1'b1, 1'b0, 3'(i), 16'h1000 + 16'(i)});
            tick();
            chk($sformatf("load_cnt_%0d", i), {ramWriteEn, loadCount}, {1'b0, 4'(i + 1)});
        end
        hostWrData = 16'h2000;
        tick();
        chk("ninth_refused", {hostWrReady, ramWriteEn, busy, ramWriteAdd, loadCount},
            {1'b0, 1'b0, 1'b0, 3'd7, 4'd8});
        tick();
        chk("ninth_still_refused", {hostWrReady, ramWriteEn, busy}, 3'b000);
        hostWrValid = 1'b0;

        // Plain pass with latency check.
        outReady = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("lat_rd", {ramReadEn, ramReadAdd, outValid, busy}, {1'b1, 3'd0, 1'b0, 1'b1});
        tick();
        chk("lat_cap", {ramReadEn, outValid}, 2'b10);
        tick();
        chk("lat_hold", {ramReadEn, outValid}, 2'b01);
        for (int k = 0; k < 8; k++) expect_word(k, 0);
        chk("pass1_done", {busy, outValid, ramReadEn}, 3'b000);

        // Pass with downstream stall on index 3.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) expect_word(k, (k == 3) ? 5 : 0);
        chk("pass2_done", {busy, outValid}, 2'b00);

        // Reset while holding index 5.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) expect_word(k, 0);
        begin
            int n = 0;
            while (!outValid && n < 20) begin
                tick();
                n++;
            end
        end
        outReady = 1'b0;
        chk("hold_idx5", {outValid, outIndex}, {1'b1, 3'd5});
        rst = 1'b1;
        tick();
        chk("mid_reset_outs", all_outs(), 64'd0);
        rst = 1'b0;
        outReady = 1'b1;

        // start and host write together: stream wins, host waits for the pass.
        hostWrValid = 1'b1;
        hostWrData = 16'h3000;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_prio", {busy, ramReadEn, hostWrReady, ramWriteEn}, 4'b1100);
        for (int k = 0; k < 8; k++) expect_word(k, 0);
        chk("host_after_pass_idle", {busy, hostWrReady}, 2'b00);
        tick();
        chk("host_after_pass_load", {hostWrReady, ramWriteEn, 1'b0, ramWriteAdd, ramDataIn},
            {1'b1, 1'b1, 1'b0, 3'd0, 16'h3000});
        exp_mem[0] = 16'h3000;
        hostWrValid = 1'b0;
        tick();
        chk("load_after_reset", {busy, loadCount}, {1'b0, 4'd1});

`ifdef PARAM_RAM_CTRL_LOOP_EN
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) expect_word(k, 0);
        chk("loop_continues", busy, 1'b1);
        for (int k = 0; k < 3; k++) expect_word(k, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 3; k < 8; k++) expect_word(k, 0);
        chk("loop_stopped", {busy, outValid}, 2'b00);
`endif

        chk("rd_wr_exclusive", 64'(excl_viol), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
